// File: rtl/cpu_mem_if.sv
// CPU request/response bundle between an initiator (master) and the memory responder (slave).
interface cpu_mem_if;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [3:0]  cpu_byte;
  logic [3:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rdata_v;
  logic [31:0] cpu_rdata;
  logic        trans_over;

  modport master (
    output cpu_wr, cpu_rd, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata_v, cpu_rdata, trans_over
  );

  modport slave (
    input  cpu_wr, cpu_rd, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_rdata_v, cpu_rdata, trans_over
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Target-side CPU endpoint: 16 x 32-bit byte-enabled store with parameterised read/write latency.
//   state   | meaning
//   IDLE    | trans_over=1, new request sampled each edge
//   WR_WAIT | write captured, counting down to store commit
//   RD_WAIT | read captured, counting down to the rdata_v pulse
module cpu_mem_responder #(
  parameter int          RD_LAT  = 2,
  parameter int          WR_LAT  = 1,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  cpu_mem_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_rd_lat_chk
    $fatal(1, "cpu_mem_responder: RD_LAT must be in 1..15");
  end
  if (WR_LAT < 1 || WR_LAT > 15) begin : g_wr_lat_chk
    $fatal(1, "cpu_mem_responder: WR_LAT must be in 1..15");
  end

  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  logic [3:0]  addr_q;
  logic [3:0]  byte_q;
  logic [31:0] wdata_q;
  logic        capture;

  logic [31:0] mem [16];

  logic        commit_en;
  logic [3:0]  commit_addr;
  logic [3:0]  commit_byte;
  logic [31:0] commit_data;
  logic        resp_en;
  logic [3:0]  resp_addr;
  logic [3:0]  resp_byte;

  logic        rdata_v_q;
  logic [31:0] rdata_q;
  logic        trans_over_q;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Single-cycle latencies act straight from the bus inputs; longer ones use the captured fields.
  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt;
    capture     = 1'b0;
    commit_en   = 1'b0;
    commit_addr = addr_q;
    commit_byte = byte_q;
    commit_data = wdata_q;
    resp_en     = 1'b0;
    resp_addr   = addr_q;
    resp_byte   = byte_q;
    case (state)
      IDLE: begin
        if (bus.cpu_wr) begin
          capture = 1'b1;
          if (WR_LAT == 1) begin
            commit_en   = 1'b1;
            commit_addr = bus.cpu_addr;
            commit_byte = bus.cpu_byte;
            commit_data = bus.cpu_wdata;
          end else begin
            next_state = WR_WAIT;
            cnt_nxt    = WR_LOAD;
          end
        end else if (bus.cpu_rd) begin
          capture = 1'b1;
          if (RD_LAT == 1) begin
            resp_en   = 1'b1;
            resp_addr = bus.cpu_addr;
            resp_byte = bus.cpu_byte;
          end else begin
            next_state = RD_WAIT;
            cnt_nxt    = RD_LOAD;
          end
        end
      end
      WR_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit_en  = 1'b1;
          next_state = IDLE;
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          resp_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_nxt    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      trans_over_q <= 1'b1;
    end else begin
      state        <= next_state;
      cnt          <= cnt_nxt;
      trans_over_q <= (next_state == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 4'd0;
      byte_q  <= 4'd0;
      wdata_q <= 32'd0;
    end else if (capture) begin
      addr_q  <= bus.cpu_addr;
      byte_q  <= bus.cpu_byte;
      wdata_q <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= RST_VAL;
    end else if (commit_en) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_byte[b]) mem[commit_addr][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  // Store is read at the response edge, so any earlier commit is already visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_v_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      rdata_v_q <= resp_en;
      rdata_q   <= resp_en ? (mem[resp_addr] & byte_mask(resp_byte)) : 32'd0;
    end
  end

  assign bus.cpu_rdata_v = rdata_v_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.trans_over  = trans_over_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: three instances with different latencies and reset values.
module tb_cpu_mem_responder;

  localparam int NI = 3;
  localparam logic [31:0] RV2 = 32'h5A5A_0F0F;

  function automatic int rdl(input int i);
    case (i)
      0: return 2;
      1: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int wrl(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]       rst_v;
  logic [NI-1:0]       wr, rd;
  logic [NI-1:0][3:0]  be, ad;
  logic [NI-1:0][31:0] wd;
  logic [NI-1:0]       rv, to;
  logic [NI-1:0][31:0] rdat;

  exp_t exp_q [NI][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    cpu_mem_if bus ();
    assign bus.cpu_wr    = wr[g];
    assign bus.cpu_rd    = rd[g];
    assign bus.cpu_byte  = be[g];
    assign bus.cpu_addr  = ad[g];
    assign bus.cpu_wdata = wd[g];
    assign rv[g]   = bus.cpu_rdata_v;
    assign to[g]   = bus.trans_over;
    assign rdat[g] = bus.cpu_rdata;

    cpu_mem_responder #(
      .RD_LAT (rdl(g)),
      .WR_LAT (wrl(g)),
      .RST_VAL((g == 2) ? RV2 : 32'h0)
    ) dut (
      .clk(clk),
      .rst(rst_v[g]),
      .bus(bus)
    );

    exp_t e;
    always @(negedge clk) begin
      if (!rst_v[g]) begin
        if (rv[g]) begin
          n_cmp++;
          if (exp_q[g].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid inst%0d: got valid with data %h at cycle %0d, required no pulse", g, rdat[g], cyc);
          end else begin
            e = exp_q[g].pop_front();
            if (rdat[g] !== e.data || cyc != e.due) begin
              n_bad++;
              $display("FAIL read_resp inst%0d: got %h at cycle %0d, required %h at cycle %0d", g, rdat[g], cyc, e.data, e.due);
            end
          end
        end else if (rdat[g] !== 32'h0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rdata_idle inst%0d: got %h while valid low, required 0", g, rdat[g]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drives one request for a single cycle; expected read data is queued when acceptance is expected.
  task automatic req(input int i, input bit w, input bit r, input logic [3:0] b,
                     input logic [3:0] a, input logic [31:0] d,
                     input bit push, input logic [31:0] exp_d);
    exp_t x;
    @(negedge clk);
    wr[i] = w; rd[i] = r; be[i] = b; ad[i] = a; wd[i] = d;
    @(posedge clk);
    #1;
    wr[i] = 1'b0; rd[i] = 1'b0;
    if (push) begin
      x.data = exp_d;
      x.due  = cyc + rdl(i) - 1;
      exp_q[i].push_back(x);
    end
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 40; k++) begin
      if (to[i]) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL idle_timeout inst%0d: trans_over still %b, required 1", i, to[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = '1; wr = '0; rd = '0; be = '0; ad = '0; wd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_trans_over%0d", i), {31'b0, to[i]}, 32'h1);
      chk($sformatf("reset_rdata_v%0d", i), {31'b0, rv[i]}, 32'h0);
      chk($sformatf("reset_rdata%0d", i), rdat[i], 32'h0);
    end

    // Instance 0: RD_LAT=2, WR_LAT=1
    req(0, 0, 1, 4'hF, 4'd5, 32'h0, 1, 32'h0000_0000);
    wait_idle(0);
    req(0, 1, 0, 4'hF, 4'd3, 32'hDEAD_BEEF, 0, 32'h0);
    chk("wr_lat1_trans_over", {31'b0, to[0]}, 32'h1);
    req(0, 1, 0, 4'b0101, 4'd3, 32'h1122_3344, 0, 32'h0);
    req(0, 0, 1, 4'hF, 4'd3, 32'h0, 1, 32'hDE22_BE44);
    wait_idle(0);
    req(0, 1, 0, 4'hF, 4'd7, 32'hA5A5_A5A5, 0, 32'h0);
    req(0, 0, 1, 4'b1000, 4'd7, 32'h0, 1, 32'hA500_0000);
    wait_idle(0);
    req(0, 1, 1, 4'hF, 4'd2, 32'h0000_CAFE, 0, 32'h0);
    req(0, 0, 1, 4'hF, 4'd2, 32'h0, 1, 32'h0000_CAFE);
    wait_idle(0);
    req(0, 0, 1, 4'hF, 4'd3, 32'h0, 1, 32'hDE22_BE44);
    @(posedge clk);
    req(0, 0, 1, 4'hF, 4'd7, 32'h0, 1, 32'hA5A5_A5A5);
    wait_idle(0);
    req(0, 1, 0, 4'b0000, 4'd7, 32'h0, 0, 32'h0);
    req(0, 0, 1, 4'hF, 4'd7, 32'h0, 1, 32'hA5A5_A5A5);
    wait_idle(0);

    // Instance 1: RD_LAT=4, WR_LAT=3, busy gating
    req(1, 1, 0, 4'hF, 4'd1, 32'h0BAD_F00D, 0, 32'h0);
    @(negedge clk);
    chk("wr_wait_trans_over", {31'b0, to[1]}, 32'h0);
    wait_idle(1);
    req(1, 0, 1, 4'hF, 4'd1, 32'h0, 1, 32'h0BAD_F00D);
    @(negedge clk);
    chk("busy_c1", {31'b0, to[1]}, 32'h0);
    wr[1] = 1'b1; be[1] = 4'hF; ad[1] = 4'd1; wd[1] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    @(negedge clk);
    chk("busy_c2", {31'b0, to[1]}, 32'h0);
    @(negedge clk);
    chk("busy_c3", {31'b0, to[1]}, 32'h0);
    @(negedge clk);
    chk("busy_release", {31'b0, to[1]}, 32'h1);
    wait_idle(1);
    req(1, 0, 1, 4'hF, 4'd1, 32'h0, 1, 32'h0BAD_F00D);
    wait_idle(1);

    // Instance 2: RD_LAT=3, WR_LAT=2, reset mid-read
    req(2, 1, 0, 4'hF, 4'd4, 32'h1234_5678, 0, 32'h0);
    wait_idle(2);
    req(2, 0, 1, 4'hF, 4'd4, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    rst_v[2] = 1'b1;
    #1;
    chk("midrst_trans_over", {31'b0, to[2]}, 32'h1);
    chk("midrst_rdata_v", {31'b0, rv[2]}, 32'h0);
    repeat (2) @(negedge clk);
    chk("midrst_hold_rdata_v", {31'b0, rv[2]}, 32'h0);
    rst_v[2] = 1'b0;
    for (int a = 0; a < 16; a++) begin
      req(2, 0, 1, 4'hF, 4'(a), 32'h0, 1, RV2);
      wait_idle(2);
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("queue_empty%0d", i), exp_q[i].size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
